// File: rtl/dzcpu_useq.sv
// dzcpu micro-op sequencer: owns the uPC, fetches opcode / CB bytes and walks flows to eof.
// Optional interrupt dispatch at instruction boundaries is built when DZCPU_IRQ_DISPATCH_EN is defined.
module dzcpu_useq #(
  parameter int                 UPC_W        = 8,
  parameter logic [UPC_W-1:0]   IRQ_FLOW_IDX = 8'd238,
  parameter int                 NUM_IRQ      = 5
) (
  input  logic               iClock,
  input  logic               iReset_n,
  input  logic               iMemValid,
  input  logic [7:0]         iMemData,
  input  logic [UPC_W-1:0]   iFlowIdx,
  input  logic [UPC_W-1:0]   iCbFlowIdx,
  input  logic               iEof,
  input  logic               iEofZ,
  input  logic               iEofNz,
  input  logic               iJcb,
  input  logic               iFlagZ,
  input  logic               iIme,
  input  logic [NUM_IRQ-1:0] iIrqPending,
  output logic [UPC_W-1:0]   oUopAddr,
  output logic [7:0]         oMop,
  output logic               oFetchReq,
  output logic [NUM_IRQ-1:0] oIrqAck,
  output logic [7:0]         oIrqVector,
  output logic               oRetire
);

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXEC     = 3'd2,
    ST_CBFETCH  = 3'd3,
    ST_CBDECODE = 3'd4
  } state_t;

  localparam logic [UPC_W-1:0] UPC_ONE = {{(UPC_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [UPC_W-1:0]  r_upc;
  logic [7:0]        r_mop;
  logic              w_end;
  logic              w_boundary;
  logic              w_take_irq;
  logic [7:0]        w_irq_vec;

  // Both conditional eofs together end the flow whatever Z is.
  assign w_end      = iEof | (iEofZ & iFlagZ) | (iEofNz & ~iFlagZ) | (iEofZ & iEofNz);
  assign w_boundary = (r_state == ST_EXEC) & ~iJcb & w_end;

`ifdef DZCPU_IRQ_DISPATCH_EN
  localparam logic [NUM_IRQ-1:0] IRQ_ONE = {{(NUM_IRQ-1){1'b0}}, 1'b1};

  function automatic logic [7:0] irq_index(input logic [NUM_IRQ-1:0] pend);
    logic [7:0] idx;
    idx = 8'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        idx = 8'(i);
      end
    end
    return idx;
  endfunction

  logic [NUM_IRQ-1:0] w_irq_low;
  logic [7:0]         w_irq_idx;
  logic [7:0]         r_irq_vec;

  assign w_irq_low  = iIrqPending & (~iIrqPending + IRQ_ONE);
  assign w_irq_idx  = irq_index(iIrqPending);
  assign w_irq_vec  = 8'h40 + {w_irq_idx[4:0], 3'b000};
  assign w_take_irq = w_boundary & iIme & (|iIrqPending);
  assign oIrqAck    = w_take_irq ? w_irq_low : {NUM_IRQ{1'b0}};
  assign oIrqVector = r_irq_vec;

  // Handler vector low byte, held until the next acknowledge.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_irq_vec <= 8'h00;
    end else if (w_take_irq) begin
      r_irq_vec <= w_irq_vec;
    end else begin
      r_irq_vec <= r_irq_vec;
    end
  end
`else
  logic w_unused_irq;

  assign w_unused_irq = iIme ^ (^iIrqPending);
  assign w_irq_vec    = 8'h00;
  assign w_take_irq   = 1'b0;
  assign oIrqAck      = {NUM_IRQ{1'b0}};
  assign oIrqVector   = 8'h00;
`endif

  // Sequencer FSM: state, uPC and latched opcode.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state <= ST_FETCH;
      r_upc   <= {UPC_W{1'b0}};
      r_mop   <= 8'h00;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (iMemValid) begin
            r_mop   <= iMemData;
            r_state <= ST_DECODE;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          r_upc   <= iFlowIdx;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (iJcb) begin
            r_state <= ST_CBFETCH;
          end else if (w_end) begin
            if (w_take_irq) begin
              r_upc   <= IRQ_FLOW_IDX;
              r_state <= ST_EXEC;
            end else begin
              r_upc   <= {UPC_W{1'b0}};
              r_state <= ST_FETCH;
            end
          end else begin
            r_upc <= r_upc + UPC_ONE;
          end
        end
        ST_CBFETCH: begin
          if (iMemValid) begin
            r_mop   <= iMemData;
            r_state <= ST_CBDECODE;
          end else begin
            r_state <= ST_CBFETCH;
          end
        end
        ST_CBDECODE: begin
          r_upc   <= iCbFlowIdx;
          r_state <= ST_EXEC;
        end
        default: begin
          r_state <= ST_FETCH;
          r_upc   <= {UPC_W{1'b0}};
        end
      endcase
    end
  end

  // Retire and ack must coincide with the eof micro-op, so they decode the live ROM bits.
  assign oRetire   = w_boundary;
  assign oUopAddr  = r_upc;
  assign oMop      = r_mop;
  assign oFetchReq = (r_state == ST_FETCH) | (r_state == ST_CBFETCH);

endmodule

// File: tb/tb_dzcpu_useq.sv
// Directed bench for dzcpu_useq: expected values are queued with each step and popped at compare time.
module tb_dzcpu_useq;

  logic       clk;
  logic       rst_n;
  logic       mem_valid;
  logic [7:0] mem_data;
  logic [7:0] flow_idx;
  logic [7:0] cb_flow_idx;
  logic       eof;
  logic       eof_z;
  logic       eof_nz;
  logic       jcb;
  logic       flag_z;
  logic       ime;
  logic [4:0] irq_pending;
  logic [7:0] uop_addr;
  logic [7:0] mop;
  logic       fetch_req;
  logic [4:0] irq_ack;
  logic [7:0] irq_vector;
  logic       retire;

  int n_cmp = 0;
  int n_err = 0;
  string       exp_tag[$];
  logic [31:0] exp_val[$];

  dzcpu_useq dut (
    .iClock      (clk),
    .iReset_n    (rst_n),
    .iMemValid   (mem_valid),
    .iMemData    (mem_data),
    .iFlowIdx    (flow_idx),
    .iCbFlowIdx  (cb_flow_idx),
    .iEof        (eof),
    .iEofZ       (eof_z),
    .iEofNz      (eof_nz),
    .iJcb        (jcb),
    .iFlagZ      (flag_z),
    .iIme        (ime),
    .iIrqPending (irq_pending),
    .oUopAddr    (uop_addr),
    .oMop        (mop),
    .oFetchReq   (fetch_req),
    .oIrqAck     (irq_ack),
    .oIrqVector  (irq_vector),
    .oRetire     (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_tag.push_back(tag);
    exp_val.push_back(val);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_cmp++;
    if (exp_val.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0h expected none", obs);
    end else begin
      t = exp_tag.pop_front();
      e = exp_val.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_ctl();
    mem_valid = 1'b0; eof = 1'b0; eof_z = 1'b0; eof_nz = 1'b0;
    jcb = 1'b0; flag_z = 1'b0; ime = 1'b0; irq_pending = 5'b00000;
  endtask

  initial begin
    rst_n = 1'b0; mem_data = 8'h00; flow_idx = 8'h00; cb_flow_idx = 8'h00;
    clear_ctl();
    repeat (2) tick();
    settle();
    expect_val("rst_upc", 32'd0);       check({24'd0, uop_addr});
    expect_val("rst_fetch_req", 32'd1); check({31'd0, fetch_req});
    expect_val("rst_mop", 32'h00);      check({24'd0, mop});
    expect_val("rst_ack", 32'd0);       check({27'd0, irq_ack});
    expect_val("rst_vec", 32'h00);      check({24'd0, irq_vector});
    expect_val("rst_retire", 32'd0);    check({31'd0, retire});
    rst_n = 1'b1;

    // Handshake: no valid for 3 cycles, nothing moves.
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      expect_val("hold_upc", 32'd0);   check({24'd0, uop_addr});
      expect_val("hold_fetch", 32'd1); check({31'd0, fetch_req});
    end

    // Multi-cycle flow: 0x31 -> flow 1, eof at uPC 4.
    mem_valid = 1'b1; mem_data = 8'h31; flow_idx = 8'd1;
    tick(); mem_valid = 1'b0; settle();
    expect_val("dec_mop", 32'h31);   check({24'd0, mop});
    expect_val("dec_fetch", 32'd0);  check({31'd0, fetch_req});
    for (int a = 1; a <= 4; a++) begin
      tick();
      if (a == 4) eof = 1'b1;
      settle();
      expect_val("flow_upc", 32'(a)); check({24'd0, uop_addr});
      expect_val("flow_retire", (a == 4) ? 32'd1 : 32'd0); check({31'd0, retire});
    end
    tick(); clear_ctl(); settle();
    expect_val("eof_upc", 32'd0);     check({24'd0, uop_addr});
    expect_val("eof_fetch", 32'd1);   check({31'd0, fetch_req});
    expect_val("eof_retire", 32'd0);  check({31'd0, retire});

    // CB prefix: 0xCB, jcb at 15 (with eof also set), CB byte 0x7C -> flow 16.
    mem_valid = 1'b1; mem_data = 8'hCB; flow_idx = 8'd15; cb_flow_idx = 8'd16;
    tick(); mem_valid = 1'b0;
    tick(); jcb = 1'b1; eof = 1'b1; settle();
    expect_val("jcb_upc", 32'd15);    check({24'd0, uop_addr});
    expect_val("jcb_retire", 32'd0);  check({31'd0, retire});
    tick(); clear_ctl(); settle();
    expect_val("cbf_fetch", 32'd1);   check({31'd0, fetch_req});
    expect_val("cbf_upc", 32'd15);    check({24'd0, uop_addr});
    mem_valid = 1'b1; mem_data = 8'h7C;
    tick(); mem_valid = 1'b0; settle();
    expect_val("cbd_mop", 32'h7C);    check({24'd0, mop});
    expect_val("cbd_upc", 32'd15);    check({24'd0, uop_addr});
    tick(); settle();
    expect_val("cb_flow_upc", 32'd16); check({24'd0, uop_addr});

    // Conditional eof: Z=0 continues at 19, Z=1 ends at 20.
    tick(); tick(); tick(); eof_z = 1'b1; flag_z = 1'b0; settle();
    expect_val("eofz_nz_upc", 32'd19);  check({24'd0, uop_addr});
    expect_val("eofz_nz_ret", 32'd0);   check({31'd0, retire});
    tick(); flag_z = 1'b1; settle();
    expect_val("eofz_z_upc", 32'd20);   check({24'd0, uop_addr});
    expect_val("eofz_z_ret", 32'd1);    check({31'd0, retire});
    tick(); clear_ctl(); settle();
    expect_val("eofz_fetch", 32'd1);    check({31'd0, fetch_req});

    // Wrap 255 -> 0; stray valid in EXEC ignored; both conditional eofs end.
    mem_valid = 1'b1; mem_data = 8'h00; flow_idx = 8'd254;
    tick(); mem_valid = 1'b0;
    tick(); tick(); settle();
    expect_val("wrap_255", 32'd255);    check({24'd0, uop_addr});
    mem_valid = 1'b1; mem_data = 8'h99;
    tick(); mem_valid = 1'b0; settle();
    expect_val("wrap_0", 32'd0);        check({24'd0, uop_addr});
    expect_val("wrap_exec", 32'd0);     check({31'd0, fetch_req});
    expect_val("ignore_mop", 32'h00);   check({24'd0, mop});
    eof_z = 1'b1; eof_nz = 1'b1; flag_z = 1'b1; settle();
    expect_val("both_eof_ret", 32'd1);  check({31'd0, retire});
    tick(); clear_ctl(); settle();
    expect_val("both_eof_upc", 32'd0);  check({24'd0, uop_addr});
    expect_val("both_eof_fetch", 32'd1); check({31'd0, fetch_req});

    // Interrupt at boundary.
    mem_valid = 1'b1; mem_data = 8'h3C; flow_idx = 8'd5;
    tick(); mem_valid = 1'b0;
    tick(); eof = 1'b1; ime = 1'b1; irq_pending = 5'b00101; settle();
    expect_val("irq_ret", 32'd1);       check({31'd0, retire});
`ifdef DZCPU_IRQ_DISPATCH_EN
    expect_val("irq_ack", 32'b00001);   check({27'd0, irq_ack});
    tick(); clear_ctl(); settle();
    expect_val("irq_upc", 32'd238);     check({24'd0, uop_addr});
    expect_val("irq_vec", 32'h40);      check({24'd0, irq_vector});
    expect_val("irq_exec", 32'd0);      check({31'd0, fetch_req});
    tick(); eof = 1'b1; irq_pending = 5'b11000; settle();
    expect_val("irqf_upc", 32'd239);    check({24'd0, uop_addr});
    expect_val("irqf_noack", 32'd0);    check({27'd0, irq_ack});
    expect_val("irqf_ret", 32'd1);      check({31'd0, retire});
    tick(); clear_ctl(); settle();
    expect_val("irqf_fetch", 32'd1);    check({31'd0, fetch_req});
    expect_val("irqf_vec_hold", 32'h40); check({24'd0, irq_vector});
    // Second interrupt picks lowest set bit 3 -> 0x58.
    mem_valid = 1'b1; flow_idx = 8'd9;
    tick(); mem_valid = 1'b0;
    tick(); eof = 1'b1; ime = 1'b1; irq_pending = 5'b11000; settle();
    expect_val("irq2_ack", 32'b01000);  check({27'd0, irq_ack});
    tick(); clear_ctl(); settle();
    expect_val("irq2_vec", 32'h58);     check({24'd0, irq_vector});
    expect_val("irq2_upc", 32'd238);    check({24'd0, uop_addr});
    tick(); eof = 1'b1; settle();
    tick(); clear_ctl(); settle();
`else
    expect_val("irq_ack_off", 32'd0);   check({27'd0, irq_ack});
    tick(); clear_ctl(); settle();
    expect_val("irq_off_upc", 32'd0);   check({24'd0, uop_addr});
    expect_val("irq_off_fetch", 32'd1); check({31'd0, fetch_req});
    expect_val("irq_off_vec", 32'h00);  check({24'd0, irq_vector});
`endif
    // Ime low: plain fetch, no ack.
    mem_valid = 1'b1; mem_data = 8'h3C; flow_idx = 8'd5;
    tick(); mem_valid = 1'b0;
    tick(); eof = 1'b1; ime = 1'b0; irq_pending = 5'b00101; settle();
    expect_val("noime_ack", 32'd0);     check({27'd0, irq_ack});
    tick(); clear_ctl(); settle();
    expect_val("noime_upc", 32'd0);     check({24'd0, uop_addr});
    expect_val("noime_fetch", 32'd1);   check({31'd0, fetch_req});

    // Reset mid-flow with an eof and pending interrupt presented.
    mem_valid = 1'b1; mem_data = 8'h77; flow_idx = 8'd7;
    tick(); mem_valid = 1'b0;
    tick(); eof = 1'b1; ime = 1'b1; irq_pending = 5'b00010;
    #1 rst_n = 1'b0; #1;
    expect_val("mrst_upc", 32'd0);      check({24'd0, uop_addr});
    expect_val("mrst_fetch", 32'd1);    check({31'd0, fetch_req});
    expect_val("mrst_mop", 32'h00);     check({24'd0, mop});
    expect_val("mrst_ack", 32'd0);      check({27'd0, irq_ack});
    expect_val("mrst_ret", 32'd0);      check({31'd0, retire});
    tick(); clear_ctl(); rst_n = 1'b1;
    tick(); settle();
    expect_val("post_rst_upc", 32'd0);  check({24'd0, uop_addr});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dzcpu_useq.md
# dzcpu_useq

Micro-op sequencer for the dzcpu core. It owns the micro-program counter (uPC) that addresses the micro-op ROM. It fetches each opcode byte and maps it to a flow index through the main and CB-prefix LUTs. It steps the flow until an end-of-flow micro-op and, at instruction boundaries, dispatches pending interrupts into a dedicated interrupt flow.

## Interface
- UPC_W, 8, width of uPC / flow index
- IRQ_FLOW_IDX, 8'd238, first ROM address of the interrupt-entry flow
- NUM_IRQ, 5, interrupt sources (VBLANK, LCDSTAT, TIMER, SERIAL, JOYPAD; bit0 highest priority)
- iClock  in  1  core clock; all state updates on rising edge
- iReset_n  in  1  asynchronous, active-low reset
- iMemValid  in  1  opcode byte on iMemData valid this cycle
- iMemData  in  8  byte read at PC
- iFlowIdx  in  UPC_W  main LUT output for oMop (combinational)
- iCbFlowIdx  in  UPC_W  CB LUT output for oMop (combinational)
- iEof  in  1  current micro-op ends the flow unconditionally
- iEofZ  in  1  current micro-op ends the flow if iFlagZ=1
- iEofNz  in  1  current micro-op ends the flow if iFlagZ=0
- iJcb  in  1  current micro-op is the CB-prefix jump
- iFlagZ  in  1  Z flag as seen by the current micro-op
- iIme  in  1  interrupt master enable
- iIrqPending  in  NUM_IRQ  IE & IF, level
- oUopAddr  out  UPC_W  ROM address (registered uPC)
- oMop  out  8  latched opcode, drives both LUTs
- oFetchReq  out  1  sequencer waiting for an opcode byte
- oIrqAck  out  NUM_IRQ  one-cycle one-hot acknowledge (clears IF bit)
- oIrqVector  out  8  low byte of handler address (0x40 + 8*n), held until next ack
- oRetire  out  1  one-cycle pulse per completed instruction or interrupt flow

## Operation
- States: FETCH, DECODE, EXEC, CBFETCH, CBDECODE.
- FETCH: oFetchReq=1; on iMemValid latch iMemData into oMop and go to DECODE; otherwise hold.
- DECODE: uPC <= iFlowIdx; go to EXEC. iFlowIdx=0 is the legal generic 1-byte flow.
- EXEC, evaluated in priority order:
  - iJcb: go to CBFETCH; uPC holds.
  - end condition true (iEof | iEofZ&iFlagZ | iEofNz&~iFlagZ): oRetire=1 and take the boundary action.
  - otherwise: uPC <= uPC+1, modulo 2^UPC_W (wraps 255->0).
- CBFETCH: same handshake as FETCH, latching the CB opcode into oMop; then CBDECODE: uPC <= iCbFlowIdx; go to EXEC.
- Boundary action:
  - If an interrupt is taken (see Configuration): uPC <= IRQ_FLOW_IDX; oIrqAck pulses the lowest set bit n of iIrqPending; oIrqVector <= 0x40+8n; state stays EXEC.
  - Otherwise: uPC <= 0 and go to FETCH.
- An interrupt flow ends like any other flow. At its eof the boundary rule is re-evaluated; iIme is expected low by then.
- iEof together with iJcb: iJcb wins. iEofZ and iEofNz together: end unconditionally.

## Timing
- Reset (async assert, sync release): state=FETCH, uPC=0, oMop=0x00, oFetchReq=1, oIrqAck=0, oIrqVector=0x00, oRetire=0.
- Opcode accepted at cycle t (iMemValid) -> DECODE at t+1 -> oUopAddr=flow index at t+2.
- One micro-op per cycle in EXEC; eof micro-op at t -> FETCH (or IRQ flow address) at t+1.
- CB prefix adds 2 cycles beyond its own fetch wait.
- oIrqAck and oRetire are asserted in the same cycle the eof micro-op is presented. iIrqPending is sampled only in that cycle.
- iMemValid outside FETCH/CBFETCH is ignored.
- iReset_n asserted mid-flow: immediate return to reset values; no ack is issued.

## Configuration
- DZCPU_IRQ_DISPATCH_EN defined: an interrupt is taken at the boundary when iIme=1 and |iIrqPending=1; oIrqAck and oIrqVector are live.
- Not defined: the boundary action always goes to FETCH; oIrqAck is tied to 0 and oIrqVector to 0x00; iIme and iIrqPending are unused.

## Test plan
- Reset: hold iReset_n=0 mid-EXEC -> oUopAddr=0, oFetchReq=1, oMop=0x00 immediately.
- Multi-cycle flow: opcode 0x31, iFlowIdx=1, iEof at uPC=4 -> oUopAddr 1,2,3,4, then FETCH, with one oRetire pulse.
- CB prefix: opcode 0xCB, iJcb at uPC=15, CB byte 0x7C, iCbFlowIdx=16 -> oMop=0x7C, oUopAddr=16 two cycles after the CB byte is accepted.
- Conditional eof: iEofZ at uPC=19 with iFlagZ=1 -> FETCH; with iFlagZ=0 -> uPC=20.
- Interrupt (macro on): iIme=1, iIrqPending=5'b00101 at eof -> oIrqAck=5'b00001, oIrqVector=0x40, next oUopAddr=238. With iIme=0 -> FETCH and no ack.
- Wrap and handshake: flow reaching uPC=255 without eof -> uPC=0. iMemValid held low for 3 cycles in FETCH -> state and uPC unchanged.
